// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared encodings and elaboration-time constant generators for the CORDIC block
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ITER = 3'd2,
    ST_GAIN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_t;

  localparam real PI_R = 3.14159265358979323846;

  // 2.0**e built by repeated doubling so only basic real arithmetic is needed
  function automatic real two_pow(input int e);
    real r;
    r = 1.0;
    for (int k = 0; k < e; k++) r = r * 2.0;
    return r;
  endfunction

  function automatic int round_pos(input real v);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int pi_fix(input int frac);
    return round_pos(PI_R * two_pow(frac));
  endfunction

  function automatic int pi_2_fix(input int frac);
    return round_pos(PI_R * 0.5 * two_pow(frac));
  endfunction

  // atan(2^-i) rounded to nearest at frac fractional bits
  function automatic int atan_fix(input int i, input int frac);
    real p;
    p = 1.0;
    for (int k = 0; k < i; k++) p = p / 2.0;
    return round_pos($atan(p) * two_pow(frac));
  endfunction

  // inverse of the accumulated CORDIC gain over n micro-rotations
  function automatic int kinv_fix(input int n, input int frac);
    real k;
    real p;
    k = 1.0;
    p = 1.0;
    for (int j = 0; j < n; j++) begin
      k = k / $sqrt(1.0 + p * p);
      p = p / 2.0;
    end
    return round_pos(k * two_pow(frac));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational lookup of atan(2^-i) for the micro-rotation index
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 13,
  parameter int N    = 14,
  parameter int IW   = 4
) (
  input  logic [IW-1:0]       idx,
  output logic signed [W-1:0] atan
);

  logic signed [W-1:0] tab [2**IW];

  // table entries are elaboration constants; indices past N-1 are never used and read as 0
  for (genvar k = 0; k < 2**IW; k++) begin : g_tab
    localparam int VAL = (k < N) ? atan_fix(k, FRAC) : 0;
    assign tab[k] = W'(VAL);
  end

  assign atan = tab[idx];

endmodule

// File: rtl/cordic_param_rtl.sv
// rtl/cordic_param_rtl.sv - iterative CORDIC engine for rotation and vectoring with gain compensation
module cordic_param_rtl
  import cordic_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 13,
  parameter int N     = 14,
  parameter int GUARD = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] angle_in,
  output logic                busy_out,
  output logic                ready_out,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] angle_out
);

  localparam int XW = W + GUARD;
  localparam int IW = $clog2(N);
  localparam int PW = XW + W + 1;

  localparam logic signed [W-1:0] PI_2     = W'(pi_2_fix(FRAC));
  localparam logic signed [W-1:0] NEG_PI_2 = -PI_2;
  localparam logic signed [W:0]   KINV     = (W + 1)'(kinv_fix(N, FRAC));

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  state_t               state;
  mode_t                mode_q;
  logic signed [XW-1:0] x_q;
  logic signed [XW-1:0] y_q;
  logic signed [W-1:0]  z_q;
  logic [IW-1:0]        i_q;
  logic                 gain_ph;
  logic signed [PW-1:0] px_q;
  logic signed [PW-1:0] py_q;

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [W-1:0]  atan_i;
  logic                 d_pos;
  logic signed [PW-1:0] px_sh;
  logic signed [PW-1:0] py_sh;

  cordic_atan_rom #(
    .W    (W),
    .FRAC (FRAC),
    .N    (N),
    .IW   (IW)
  ) u_atan_rom (
    .idx  (i_q),
    .atan (atan_i)
  );

  // rotation steers z to zero, vectoring steers y to zero
  assign d_pos = (mode_q == MODE_ROT) ? ~z_q[W-1] : y_q[XW-1];
  assign x_sh  = x_q >>> i_q;
  assign y_sh  = y_q >>> i_q;
  assign px_sh = px_q >>> FRAC;
  assign py_sh = py_q >>> FRAC;

  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
    else                  return v[W-1:0];
  endfunction

  // sequencer and datapath; the gain step is split into a multiply phase and a scale/saturate phase
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ROT;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      gain_ph   <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      busy_out  <= 1'b0;
      ready_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      angle_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode_t'(mode);
            x_q       <= XW'(x_in);
            y_q       <= XW'(y_in);
            z_q       <= mode ? '0 : angle_in;
            i_q       <= '0;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
            state     <= ST_PRE;
          end
        end
        ST_PRE: begin
          // quadrant fold so the micro-rotations only need to cover +/- pi/2
          if (mode_q == MODE_ROT) begin
            if (z_q > PI_2) begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= z_q - PI_2;
            end else if (z_q < NEG_PI_2) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= z_q + PI_2;
            end
          end else if (x_q[XW-1]) begin
            if (!y_q[XW-1]) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= PI_2;
            end else begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= NEG_PI_2;
            end
          end
          state <= ST_ITER;
        end
        ST_ITER: begin
          if (d_pos) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end
          i_q <= i_q + IW'(1);
          if (i_q == IW'(N - 1)) begin
            gain_ph <= 1'b0;
            state   <= ST_GAIN;
          end
        end
        ST_GAIN: begin
          if (!gain_ph) begin
            px_q    <= PW'(x_q) * PW'(KINV);
            py_q    <= PW'(y_q) * PW'(KINV);
            gain_ph <= 1'b1;
          end else begin
            x_out     <= sat(px_sh);
            y_out     <= sat(py_sh);
            angle_out <= z_q;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            gain_ph   <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_param_rtl.sv
// tb/tb_cordic_param_rtl.sv - randomized and directed self-checking bench for cordic_param_rtl
module tb_cordic_param_rtl;

  localparam int  W     = 16;
  localparam int  FRAC  = 13;
  localparam int  N     = 14;
  localparam int  LAT   = N + 3;
  localparam int  TOL   = 9;
  localparam real SCALE = 8192.0;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                mode  = 1'b0;
  logic signed [W-1:0] x_in  = '0;
  logic signed [W-1:0] y_in  = '0;
  logic signed [W-1:0] angle_in = '0;
  logic                busy_out;
  logic                ready_out;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] angle_out;

  int checks = 0;
  int errors = 0;

  cordic_param_rtl #(.W(W), .FRAC(FRAC), .N(N), .GUARD(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_in  (angle_in),
    .busy_out  (busy_out),
    .ready_out (ready_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .angle_out (angle_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int rnd_sat(input real v);
    int r;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // ideal math: true rotation, or magnitude and atan2 for vectoring
  task automatic model(input logic m, input int x, input int y, input int a,
                       output int ex, output int ey, output int ez);
    real th;
    if (!m) begin
      th = a / SCALE;
      ex = rnd_sat(x * $cos(th) - y * $sin(th));
      ey = rnd_sat(x * $sin(th) + y * $cos(th));
      ez = 0;
    end else begin
      ex = rnd_sat($sqrt(real'(x) * x + real'(y) * y));
      ey = 0;
      ez = rnd_sat($atan2(real'(y), real'(x)) * SCALE);
    end
  endtask

  // issue one job with a single-cycle start pulse; lat is -1 on timeout
  task automatic do_job(input logic m, input int x, input int y, input int a,
                        output int lat, output int bad_busy);
    @(negedge clock);
    mode = m; x_in = 16'(x); y_in = 16'(y); angle_in = 16'(a); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    bad_busy = 0;
    if (!busy_out) bad_busy++;
    if (ready_out) bad_busy++;
    while (lat < 60) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (ready_out) break;
      if (!busy_out) bad_busy++;
    end
    if (!ready_out) lat = -1;
    else if (busy_out) bad_busy++;
  endtask

  task automatic job_check(input string tag, input logic m, input int x, input int y, input int a);
    int ex, ey, ez, lat, bb;
    model(m, x, y, a, ex, ey, ez);
    do_job(m, x, y, a, lat, bb);
    check_val({tag, "_lat"}, lat, LAT, 0);
    check_val({tag, "_busy"}, bb, 0, 0);
    check_val({tag, "_x"}, int'(x_out), ex, TOL);
    check_val({tag, "_y"}, int'(y_out), ey, TOL);
    check_val({tag, "_ang"}, int'(angle_out), ez, TOL);
  endtask

  initial begin
    int ex, ey, ez, exb, eyb, ezb, lat, bb, x, y, a, starts, rdy_cnt;
    logic prev_busy;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_busy", int'(busy_out), 0, 0);
    check_val("rst_ready", int'(ready_out), 0, 0);
    check_val("rst_x", int'(x_out), 0, 0);
    check_val("rst_y", int'(y_out), 0, 0);
    check_val("rst_ang", int'(angle_out), 0, 0);
    reset = 1'b1;

    job_check("rot30", 1'b0, 8192, 0, 4289);
    check_val("rot30_xref", int'(x_out), 7094, TOL);
    check_val("rot30_yref", int'(y_out), 4096, TOL);
    job_check("pre150", 1'b0, 8192, 0, 21447);
    check_val("pre150_xref", int'(x_out), -7094, TOL);
    job_check("pre_m150", 1'b0, 8192, 0, -21447);
    check_val("pre_m150_yref", int'(y_out), -4096, TOL);
    job_check("vec_q1", 1'b1, 6144, 8192, 0);
    check_val("vec_q1_magref", int'(x_out), 10240, TOL);
    check_val("vec_q1_angref", int'(angle_out), 7596, TOL);
    job_check("vec_q2", 1'b1, -6144, 8192, 0);
    check_val("vec_q2_angref", int'(angle_out), 18140, TOL);
    job_check("vec_q3", 1'b1, -6144, -8192, 0);

    for (int k = 0; k < 20; k++) begin
      x = int'($urandom_range(0, 12000)) - 6000;
      y = int'($urandom_range(0, 12000)) - 6000;
      a = int'($urandom_range(0, 51470)) - 25735;
      job_check("rand_rot", 1'b0, x, y, a);
    end
    for (int k = 0; k < 20; k++) begin
      do begin
        x = int'($urandom_range(0, 12000)) - 6000;
        y = int'($urandom_range(0, 12000)) - 6000;
      end while (x * x + y * y < 4000000);
      job_check("rand_vec", 1'b1, x, y, int'($urandom_range(0, 1000)));
    end

    // start held high for 40 cycles must run exactly one job
    model(1'b0, 8192, 0, 4289, ex, ey, ez);
    @(negedge clock);
    mode = 1'b0; x_in = 16'(8192); y_in = 16'(0); angle_in = 16'(4289); start = 1'b1;
    starts = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (busy_out && !prev_busy) starts++;
      prev_busy = busy_out;
    end
    check_val("hold_starts", starts, 1, 0);
    check_val("hold_ready", int'(ready_out), 1, 0);
    check_val("hold_busy", int'(busy_out), 0, 0);
    check_val("hold_x", int'(x_out), ex, TOL);
    start = 1'b0;
    @(posedge clock);
    model(1'b1, 6144, 8192, 0, exb, eyb, ezb);
    @(negedge clock);
    mode = 1'b1; x_in = 16'(6144); y_in = 16'(8192); angle_in = 16'(0); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check_val("rearm_busy", int'(busy_out), 1, 0);
    check_val("rearm_ready", int'(ready_out), 0, 0);
    lat = 0;
    while (lat < 60) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 10) begin
        check_val("rearm_hold_x", int'(x_out), ex, TOL);
        check_val("rearm_hold_y", int'(y_out), ey, TOL);
      end
      if (ready_out) break;
    end
    if (!ready_out) lat = -1;
    check_val("rearm_lat", lat, LAT, 0);
    check_val("rearm_x", int'(x_out), exb, TOL);
    check_val("rearm_ang", int'(angle_out), ezb, TOL);

    // reset asserted at the eighth edge of a job
    @(negedge clock);
    mode = 1'b0; x_in = 16'(8192); y_in = 16'(0); angle_in = 16'(4289); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (7) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("abort_busy", int'(busy_out), 0, 0);
    check_val("abort_ready", int'(ready_out), 0, 0);
    check_val("abort_x", int'(x_out), 0, 0);
    check_val("abort_y", int'(y_out), 0, 0);
    check_val("abort_ang", int'(angle_out), 0, 0);
    reset = 1'b1;
    rdy_cnt = 0;
    repeat (30) begin
      @(posedge clock);
      @(negedge clock);
      if (ready_out || busy_out) rdy_cnt++;
    end
    check_val("abort_quiet", rdy_cnt, 0, 0);
    job_check("post_abort", 1'b0, 0, 8192, -4289);

    // ideal result far above full scale must clip, never wrap
    do_job(1'b0, 32767, -32767, 6434, lat, bb);
    check_val("sat_lat", lat, LAT, 0);
    check_val("sat_clip", int'(x_out), 32767, 0);
    do_job(1'b0, 32767, 32767, 0, lat, bb);
    check_val("sat_edge_x", int'(x_out), 32767, TOL);
    check_val("sat_edge_y", int'(y_out), 32767, TOL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_param_rtl.md
CORDIC_PARAM_RTL -- requirements
Module: cordic_param_rtl

Interface
REQ-001 Parameter W, default 16, data/angle word width (signed two's complement).
REQ-002 Parameter FRAC, default 13, fractional bits of all data and angle words (radians); 1.0 = 2^FRAC.
REQ-003 Parameter N, default 14, number of micro-rotations; legal range 4..W-2.
REQ-004 Parameter GUARD, default 2, extra internal MSBs on x/y datapath.
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 mode  input  1  0 = rotation (rotate (x,y) by angle_in), 1 = vectoring (magnitude/atan2 of (x,y)).
REQ-009 x_in, y_in  input  W each  initial vector.
REQ-010 angle_in  input  W  rotation angle, any value in [-pi, pi]; ignored in vectoring.
REQ-011 busy_out  output  1  high while a job is in progress.
REQ-012 ready_out  output  1  results valid.
REQ-013 x_out, y_out  output  W each  gain-compensated result vector.
REQ-014 angle_out  output  W  residual angle (rotation) or atan2(y,x) (vectoring).

Function
REQ-015 States SHALL be IDLE, PRE, ITER, GAIN, DONE; IDLE->PRE when start=1, PRE->ITER, ITER->ITER while i<N-1 else GAIN, GAIN->DONE, DONE->IDLE when start=0 else stay.
REQ-016 In IDLE with start=1 the block SHALL register mode, x_in, y_in, angle_in (z=angle_in rotation, z=0 vectoring), clear i, drop ready_out.
REQ-017 PRE rotation: z>pi/2 -> (x,y)=(-y,x), z-=pi/2; z<-pi/2 -> (x,y)=(y,-x), z+=pi/2; else unchanged.
REQ-018 PRE vectoring: x<0 and y>=0 -> (x,y)=(y,-x), z=+pi/2; x<0 and y<0 -> (x,y)=(-y,x), z=-pi/2; else unchanged.
REQ-019 ITER SHALL perform exactly one micro-rotation per cycle: d=+1 if (rotation and z>=0) or (vectoring and y<0), else -1; x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*atan(2^-i); i increments.
REQ-020 Shifts SHALL be arithmetic, variable by i; x/y internal width W+GUARD; z width W.
REQ-021 atan(2^-i) constants SHALL be round-to-nearest at FRAC bits for i=0..N-1.
REQ-022 GAIN SHALL multiply x and y by KINV=round(prod(1/sqrt(1+2^-2i)) * 2^FRAC), arithmetic-shift right FRAC, saturate to W bits.
REQ-023 Latency: start sampled at edge t -> ready_out and outputs valid after edge t+N+3.
REQ-024 busy_out SHALL be high from edge t through edge t+N+2, low in IDLE and DONE.
REQ-025 Outputs and ready_out SHALL hold in DONE until start=0; start held high SHALL NOT retrigger; a new job requires start low then high.
REQ-026 Outputs SHALL only update on DONE entry; they hold the previous result during a new job.
REQ-027 Accuracy: |error| <= N/2+2 LSB versus ideal, for |(x,y)|*1.65 below saturation.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, busy_out=0, ready_out=0, x_out=y_out=angle_out=0, i=0, from any state including mid-ITER.
REQ-029 An aborted job SHALL produce no ready_out; the first start after reset release starts a fresh job.

Structure
REQ-030 Package cordic_pkg SHALL hold: state encoding, mode encoding, PI/PI_2 constants, atan-table and KINV generation functions parameterised by FRAC/N.
REQ-031 One sub-module, cordic_atan_rom (i -> atan(2^-i), combinational), SHALL be instantiated; all else in cordic_param_rtl.

Verification (W=16, FRAC=13, N=14, tolerance +/-9 LSB)
REQ-032 Rotation: x_in=8192, y_in=0, angle_in=4289 (pi/6) -> x_out~7094, y_out~4096, ready_out after exactly 17 cycles.
REQ-033 Pre-rotation: x_in=8192, y_in=0, angle_in=21447 (5pi/6) -> x_out~-7094, y_out~4096; angle_in=-21447 -> x_out~-7094, y_out~-4096.
REQ-034 Vectoring: x_in=6144, y_in=8192 -> x_out~10240, y_out~0, angle_out~7596; x_in=-6144, y_in=8192 -> angle_out~18140.
REQ-035 Handshake: start held high 40 cycles -> one job only, ready_out stays high; start low 1 cycle then high -> second job, outputs held until DONE.
REQ-036 Reset mid-ITER (cycle 8 of job) -> next edge all outputs 0, IDLE; no ready_out; following job correct.
REQ-037 Saturation: x_in=y_in=32767, angle_in=0 -> x_out=32767 within one LSB of clip, no wrap to negative.
